// File: rtl/bec_la_pkg.sv
// Shared constants, state encoding and command-word helpers for the BEC LA host sequencer.
package bec_la_pkg;

  localparam int unsigned OpW       = 163;
  localparam int unsigned NumOps    = 7;
  localparam int unsigned CmdW      = 128;
  localparam int unsigned TagW      = 14;
  localparam int unsigned PayW      = 82;
  localparam int unsigned HiW       = 81;
  localparam int unsigned LoW       = 82;

  localparam int unsigned OpcLsb    = 16;
  localparam int unsigned OpcMsb    = 31;
  localparam int unsigned TagLsb    = 82;
  localparam int unsigned TagMsb    = 95;
  localparam int unsigned PayMsb    = 81;

  localparam logic [15:0] OpcLoad    = 16'hAB30;
  localparam logic [15:0] OpcStart   = 16'hAB41;
  localparam logic [15:0] OpcRdHi    = 16'hAB08;
  localparam logic [15:0] OpcRdLo    = 16'hAB0C;
  localparam logic [15:0] OpcRelease = 16'hAB50;

  localparam logic [5:0] StsLoadDone = 6'b011110;
  localparam logic [5:0] StsStartAck = 6'b100111;
  localparam logic [7:0] StsRdHi     = 8'hCC;
  localparam logic [7:0] StsRdLo     = 8'hD0;

  localparam logic [3:0] LastHalf    = 4'd13;

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StRdHi, StRdLo, StRelease, StResult, StErr
  } seq_state_e;

  // Thermometer tag with h+1 ones.
  function automatic logic [TagW-1:0] half_tag(input logic [3:0] h);
    logic [TagW-1:0] t;
    t = '0;
    for (int i = 0; i < int'(TagW); i++) t[i] = (i <= int'(h));
    return t;
  endfunction

  // The payload field overlaps the opcode field; both are OR-merged into the word.
  function automatic logic [CmdW-1:0] make_cmd(input logic [15:0] opc,
                                               input logic [TagW-1:0] tag,
                                               input logic [PayW-1:0] pay);
    logic [CmdW-1:0] c;
    c = '0;
    c[PayMsb:0] = pay;
    c[OpcMsb:OpcLsb] = c[OpcMsb:OpcLsb] | opc;
    c[TagMsb:TagLsb] = tag;
    return c;
  endfunction

endpackage

// File: rtl/la_seq_watchdog.sv
// Wait-state cycle counter with expiry flag; cleared whenever the sequencer makes progress.
module la_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/la_host_sequencer.sv
// Host sequencer driving the BEC controller LA port: load 7 operands, compute, read result.
// Optional wait-state timeout enabled by defining LA_SEQ_TIMEOUT_EN.
module la_host_sequencer
  import bec_la_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OpW-1:0]   op_data,
  output logic [CmdW-1:0]  la_cmd,
  input  logic [CmdW-1:0]  la_status,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OpW-1:0]   res_data,
  output logic             busy,
  output logic             err
);

  seq_state_e      state_q, state_d;
  logic [3:0]      h_q, h_d;
  logic            have_op_q, have_op_d;
  logic [LoW-1:0]  lo_q, lo_d;
  logic [OpW-1:0]  res_q, res_d;
  logic [CmdW-1:0] la_cmd_q, la_cmd_d;
  logic            echo_ok;
  logic            expired;

  logic unused_status;
  assign unused_status = ^{la_status[119:114], la_status[31:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      h_q       <= '0;
      have_op_q <= 1'b0;
      lo_q      <= '0;
      res_q     <= '0;
      la_cmd_q  <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      have_op_q <= have_op_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      la_cmd_q  <= la_cmd_d;
    end
  end

  // The last half is acknowledged with a distinct 6-bit code rather than a count.
  assign echo_ok = (h_q == LastHalf) ? (la_status[127:122] == StsLoadDone)
                                     : (la_status[125:122] == h_q + 4'd1);

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    have_op_d = have_op_q;
    lo_d      = lo_q;
    res_d     = res_q;
    la_cmd_d  = la_cmd_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (start) begin
          state_d   = StLoad;
          h_d       = '0;
          have_op_d = 1'b0;
          la_cmd_d  = '0;
        end
      end
      StLoad: begin
        if (!have_op_q) begin
          if (op_valid) begin
            have_op_d = 1'b1;
            lo_d      = op_data[LoW-1:0];
            la_cmd_d  = make_cmd(OpcLoad, half_tag(h_q), {1'b0, op_data[OpW-1:LoW]});
          end
        end else if (echo_ok) begin
          if (h_q == LastHalf) begin
            state_d  = StStart;
            la_cmd_d = make_cmd(OpcStart, '1, '0);
          end else begin
            h_d = h_q + 4'd1;
            if (!h_q[0]) begin
              la_cmd_d = make_cmd(OpcLoad, half_tag(h_q + 4'd1), lo_q);
            end else begin
              // Next even half needs a fresh operand; la_cmd holds until it arrives.
              have_op_d = 1'b0;
            end
          end
        end else if (expired) begin
          state_d  = StErr;
          la_cmd_d = '0;
        end
      end
      StStart: begin
        if (la_status[127:122] == StsStartAck) begin
          state_d  = StRdHi;
          la_cmd_d = make_cmd(OpcRdHi, '0, '0);
        end else if (expired) begin
          state_d  = StErr;
          la_cmd_d = '0;
        end
      end
      StRdHi: begin
        if (la_status[127:120] == StsRdHi) begin
          state_d              = StRdLo;
          res_d[OpW-1:LoW]     = la_status[112:32];
          la_cmd_d             = make_cmd(OpcRdLo, '0, '0);
        end else if (expired) begin
          state_d  = StErr;
          la_cmd_d = '0;
        end
      end
      StRdLo: begin
        if (la_status[127:120] == StsRdLo) begin
          state_d          = StRelease;
          res_d[LoW-1:0]   = la_status[113:32];
          la_cmd_d         = make_cmd(OpcRelease, '0, '0);
        end else if (expired) begin
          state_d  = StErr;
          la_cmd_d = '0;
        end
      end
      StRelease: begin
        if (la_status[127:122] == 6'b000000) begin
          state_d  = StResult;
          la_cmd_d = '0;
        end else if (expired) begin
          state_d  = StErr;
          la_cmd_d = '0;
        end
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        la_cmd_d = '0;
      end
    endcase
  end

`ifdef LA_SEQ_TIMEOUT_EN
  logic waiting;
  logic wd_clr;

  assign waiting = ((state_q == StLoad) && have_op_q) ||
                   (state_q inside {StStart, StRdHi, StRdLo, StRelease});
  assign wd_clr  = (state_d != state_q) || (h_d != h_q) || !waiting;

  la_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clr_i     (wd_clr),
    .en_i      (waiting),
    .expired_o (expired)
  );

  assign err = (state_q == StErr);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
  assign err            = 1'b0;
`endif

  assign op_ready  = (state_q == StLoad) && !have_op_q;
  assign busy      = !(state_q inside {StIdle, StErr});
  assign res_valid = (state_q == StResult);
  assign res_data  = res_q;
  assign la_cmd    = la_cmd_q;

endmodule

// File: doc/la_host_sequencer.md
LA_HOST_SEQUENCER -- requirements
Module: la_host_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent in any wait state before an error.
REQ-002 wb_clk_i  input  1  sole clock; every register is updated on its rising edge.
REQ-003 wb_rst_i  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  pulse that begins one 7-operand load/compute/read transaction; ignored while busy.
REQ-005 op_valid, op_ready  input/output  1/1  operand handshake; transfer occurs when both are high on the same edge.
REQ-006 op_data  input  163  operand, supplied in order w1, z1, w2, z2, inv_w0, d, k.
REQ-007 la_cmd  output  128  registered command word driven into the BEC controller's LA input.
REQ-008 la_status  input  128  status word returned from the BEC controller's LA output.
REQ-009 res_valid, res_ready  output/input  1/1  result handshake.
REQ-010 res_data  output  163  result read back from the BEC.
REQ-011 busy, err  output  1/1  busy: transaction in progress; err: sticky timeout flag.

Function
REQ-012 States SHALL be IDLE, LOAD, START, RD_HI, RD_LO, RELEASE, RESULT and ERR.
REQ-013 Command field mapping: la_cmd[31:16] carries the opcode, la_cmd[95:82] the half tag, la_cmd[81:0] the payload; all unused bits SHALL be 0.
REQ-014 IDLE: la_cmd = 0; start moves to LOAD with half index h = 0 and sets busy.
REQ-015 LOAD: opcode 16'hAB30; tag = 14-bit thermometer with h+1 ones.
REQ-016 LOAD, even h: op_ready = 1 until an operand is accepted; the accepted operand is latched, and the next cycle drives op[162:82] into la_cmd[80:0].
REQ-017 LOAD, odd h: the latched op[81:0] is driven into la_cmd[81:0].
REQ-018 LOAD advances h when the echo matches: la_status[125:122] == h+1 for h = 0..12, or la_status[127:122] == 6'b011110 for h = 13.
REQ-019 After h = 13 matches, the FSM enters START; la_cmd holds its value until each echo matches.
REQ-020 START: opcode 16'hAB41, tag all ones; advance to RD_HI when la_status[127:122] == 6'b100111.
REQ-021 RD_HI: opcode 16'hAB08 is driven continuously, including during computation.
REQ-022 RD_HI exit: when la_status[127:120] == 8'hCC, capture la_status[112:32] into res[162:82] and go to RD_LO.
REQ-023 RD_LO: opcode 16'hAB0C; when la_status[127:120] == 8'hD0, capture la_status[113:32] into res[81:0] and go to RELEASE.
REQ-024 RELEASE: opcode 16'hAB50 with la_cmd[32] = 0; go to RESULT when la_status[127:122] == 6'b000000.
REQ-025 RESULT: la_cmd = 0, res_valid = 1, res_data stable until res_ready; then return to IDLE and clear busy.
REQ-026 Echo comparison SHALL use la_status sampled at the edge; the minimum per-half latency is 2 cycles.
REQ-027 A start pulse arriving in the same cycle as a res_ready acceptance SHALL be ignored.
REQ-028 op_valid outside an op_ready window SHALL be ignored.

Reset
REQ-029 Reset values: la_cmd = 0, op_ready = 0, res_valid = 0, res_data = 0, busy = 0, err = 0, state IDLE, h = 0.
REQ-030 Assertion of reset mid-transaction SHALL abort it immediately; no partial result is emitted.

Configuration
REQ-031 With LA_SEQ_TIMEOUT_EN defined, a counter SHALL reset on every state change.
REQ-032 With the macro defined, the counter reaching TIMEOUT_CYCLES in LOAD (echo wait), START, RD_HI, RD_LO or RELEASE enters ERR.
REQ-033 ERR: la_cmd = 0, err = 1, busy = 0; a start pulse clears err and begins a new transaction.
REQ-034 Without the macro, no counter exists, err is tied to 0, and wait states wait indefinitely.

Structure
REQ-035 Package bec_la_pkg SHALL hold opcodes (AB30/AB41/AB08/AB0C/AB50), status codes (011110, 100111, CC, D0), the field bit positions, the 163-bit operand width, the operand count of 7 and the state enum.
REQ-036 Sub-module la_seq_watchdog (counter plus expiry flag) SHALL be instantiated only under LA_SEQ_TIMEOUT_EN.

Verification
REQ-037 Responder model echoing per protocol, 7 operands 163'h1..163'h7 -> 14 commands seen with tags 0x0001..0x3FFF, payload halves correct, then AB41.
REQ-038 Responder returns CC with [112:32] = 81'h1ABC and D0 with [113:32] = 82'h2DEF -> res_data = {81'h1ABC, 82'h2DEF}, res_valid held until res_ready.
REQ-039 op_valid withheld 10 cycles at h = 4 -> la_cmd unchanged, op_ready high throughout, no tag advance.
REQ-040 Macro on, TIMEOUT_CYCLES = 16, no echo at h = 3 -> err = 1 after 16 cycles, la_cmd = 0; a subsequent start clears err.
REQ-041 Reset asserted in RD_HI -> next edge shows all outputs at their reset values, state IDLE.
REQ-042 start pulsed during LOAD -> ignored; exactly one transaction completes.
